// File: rtl/rgb2yuv_pkg.sv
// Shared definitions for the frame-level RGB -> YCbCr (BT.601, 4:4:4) converter.
// Contents: FSM state encoding, accumulator width, matrix coefficients,
// output offsets and the rounding constant used before the >>> 8 shift.
package rgb2yuv_pkg;

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, CAP, CALC, WY, WU, WV, DONE
  } state_t;

  localparam int ACC_W = 18;

  localparam logic signed [ACC_W-1:0] CY_R = 18'sd66;
  localparam logic signed [ACC_W-1:0] CY_G = 18'sd129;
  localparam logic signed [ACC_W-1:0] CY_B = 18'sd25;
  localparam logic signed [ACC_W-1:0] CU_R = -18'sd38;
  localparam logic signed [ACC_W-1:0] CU_G = -18'sd74;
  localparam logic signed [ACC_W-1:0] CU_B = 18'sd112;
  localparam logic signed [ACC_W-1:0] CV_R = 18'sd112;
  localparam logic signed [ACC_W-1:0] CV_G = -18'sd94;
  localparam logic signed [ACC_W-1:0] CV_B = -18'sd18;

  localparam logic signed [ACC_W-1:0] OFS_Y = 18'sd16;
  localparam logic signed [ACC_W-1:0] OFS_C = 18'sd128;
  localparam logic signed [ACC_W-1:0] RND   = 18'sd128;

endpackage

// File: rtl/rgb_to_yuv_conversion_if.sv
// Frame SRAM bus used by the RGB -> YCbCr converter.
//   R_addr  read address  (converter -> SRAM)
//   R_data  read data, valid the cycle after R_addr (SRAM -> converter)
//   Wrenb   write enable, active-high
//   W_addr  write address
//   W_data  write data
// Modports: master = converter side, slave = SRAM side.
interface rgb_to_yuv_conversion_if #(
  parameter int AW = 18
);
  logic [AW-1:0] R_addr;
  logic [15:0]   R_data;
  logic          Wrenb;
  logic [AW-1:0] W_addr;
  logic [15:0]   W_data;

  modport master (output R_addr, Wrenb, W_addr, W_data, input R_data);
  modport slave  (input R_addr, Wrenb, W_addr, W_data, output R_data);
endinterface

// File: rtl/rgb2yuv_pixel.sv
// Combinational single-pixel BT.601 matrix: {r,g,b} -> {y,u,v}.
// Ports: r, g, b (8-bit unsigned in); y, u, v (8-bit out).
// Signed 18-bit accumulators; the shift is an arithmetic (floor) shift and
// only the low 8 bits of the offset result are kept (inputs keep it in 16..240).
module rgb2yuv_pixel
  import rgb2yuv_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic [7:0] u,
  output logic [7:0] v
);

  logic signed [ACC_W-1:0] r_s, g_s, b_s;
  logic signed [ACC_W-1:0] acc_y, acc_u, acc_v;

  function automatic logic [7:0] round_off(input logic signed [ACC_W-1:0] acc,
                                           input logic signed [ACC_W-1:0] ofs);
    logic signed [ACC_W-1:0] t;
    t = ((acc + RND) >>> 8) + ofs;
    return t[7:0];
  endfunction

  always_comb begin
    r_s   = signed'({10'd0, r});
    g_s   = signed'({10'd0, g});
    b_s   = signed'({10'd0, b});
    acc_y = CY_R * r_s + CY_G * g_s + CY_B * b_s;
    acc_u = CU_R * r_s + CU_G * g_s + CU_B * b_s;
    acc_v = CV_R * r_s + CV_G * g_s + CV_B * b_s;
    y     = round_off(acc_y, OFS_Y);
    u     = round_off(acc_u, OFS_C);
    v     = round_off(acc_v, OFS_C);
  end

endmodule

// File: rtl/rgb_to_yuv_conversion.sv
// Frame-level RGB -> YCbCr (BT.601, 4:4:4) converter.
// Reads packed RGB pixel pairs {R0,G0},{B0,R1},{G1,B1} from RGB_BASE+3k and
// writes {Y0,Y1},{U0,U1},{V0,V1} to Y_BASE+k, U_BASE+k, V_BASE+k (pixel 0 in
// bits [15:8]). Eight cycles per pair: RD0 RD1 RD2 CAP CALC WY WU WV.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous reset, active-low
//   clear  synchronous abort: FSM to IDLE, all registers zeroed
//   start  1-cycle pulse, accepted only in IDLE
//   done   1-cycle pulse after the last V write
//   bus    frame SRAM bus (master modport)
//   checksum  only with RGB2YUV_CHECKSUM_EN defined: wrapping 16-bit sum of
//             every written word, zeroed by rst, clear and an accepted start
module rgb_to_yuv_conversion
  import rgb2yuv_pkg::*;
#(
  parameter int NUM_PAIRS = 38400,
  parameter int AW        = 18,
  parameter int RGB_BASE  = 0,
  parameter int Y_BASE    = 115200,
  parameter int U_BASE    = 153600,
  parameter int V_BASE    = 192000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  output logic done,
  rgb_to_yuv_conversion_if.master bus
`ifdef RGB2YUV_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [AW-1:0] LAST_K = AW'(NUM_PAIRS - 1);

  state_t state, state_nx;
  logic [AW-1:0] k;
  logic [15:0] rgb0_p0, rgb1_p0, rgb2_p0;
  logic [15:0] u_p1, v_p1;
  logic [7:0]  y0, u0, v0, y1, u1, v1;

  rgb2yuv_pixel u_pix0 (
    .r(rgb0_p0[15:8]), .g(rgb0_p0[7:0]), .b(rgb1_p0[15:8]),
    .y(y0), .u(u0), .v(v0)
  );

  rgb2yuv_pixel u_pix1 (
    .r(rgb1_p0[7:0]), .g(rgb2_p0[15:8]), .b(rgb2_p0[7:0]),
    .y(y1), .u(u1), .v(v1)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RD0;
      RD0:     state_nx = RD1;
      RD1:     state_nx = RD2;
      RD2:     state_nx = CAP;
      CAP:     state_nx = CALC;
      CALC:    state_nx = WY;
      WY:      state_nx = WU;
      WU:      state_nx = WV;
      WV:      state_nx = (k == LAST_K) ? DONE : RD0;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // All bus outputs are registered from the next state, so they line up with
  // the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      done       <= 1'b0;
      bus.Wrenb  <= 1'b0;
      bus.R_addr <= '0;
      bus.W_addr <= '0;
      bus.W_data <= '0;
      rgb0_p0    <= '0;
      rgb1_p0    <= '0;
      rgb2_p0    <= '0;
      u_p1       <= '0;
      v_p1       <= '0;
    end else if (clear) begin
      state      <= IDLE;
      k          <= '0;
      done       <= 1'b0;
      bus.Wrenb  <= 1'b0;
      bus.R_addr <= '0;
      bus.W_addr <= '0;
      bus.W_data <= '0;
      rgb0_p0    <= '0;
      rgb1_p0    <= '0;
      rgb2_p0    <= '0;
      u_p1       <= '0;
      v_p1       <= '0;
    end else begin
      state     <= state_nx;
      done      <= (state_nx == DONE);
      bus.Wrenb <= (state_nx == WY) || (state_nx == WU) || (state_nx == WV);

      // Read address walks RGB_BASE+3k .. +2; the next pair's first word is
      // simply the following address.
      unique case (state)
        IDLE:     if (start) bus.R_addr <= AW'(RGB_BASE);
        RD0, RD1: bus.R_addr <= bus.R_addr + AW'(1);
        WV:       if (state_nx == RD0) bus.R_addr <= bus.R_addr + AW'(1);
        default:  ;
      endcase

      // Stage p0: capture the three RGB words one cycle after each address
      if (state == RD1) rgb0_p0 <= bus.R_data;
      if (state == RD2) rgb1_p0 <= bus.R_data;
      if (state == CAP) rgb2_p0 <= bus.R_data;

      // Stage p1: matrix results; the Y word goes straight into W_data
      if (state == CALC) begin
        u_p1       <= {u0, u1};
        v_p1       <= {v0, v1};
        bus.W_addr <= AW'(Y_BASE) + k;
        bus.W_data <= {y0, y1};
      end
      if (state == WY) begin
        bus.W_addr <= AW'(U_BASE) + k;
        bus.W_data <= u_p1;
      end
      if (state == WU) begin
        bus.W_addr <= AW'(V_BASE) + k;
        bus.W_data <= v_p1;
      end
      if (state == WV) k <= (k == LAST_K) ? '0 : k + AW'(1);
    end
  end

`ifdef RGB2YUV_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (clear || (state == IDLE && start)) begin
      checksum <= '0;
    end else if (bus.Wrenb) begin
      checksum <= checksum + bus.W_data;
    end
  end
`endif

endmodule
